dmux8way_dispatcher: RTL and testbench



---
 rtl/dmux8way_dispatcher_pkg.sv | 22 ++
 rtl/DMux8Way.sv | 27 ++
 rtl/rr_pick8.sv | 34 +++
 rtl/dmux8way_dispatcher.sv | 123 ++++++++++++
 tb/tb_dmux8way_dispatcher.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmux8way_dispatcher_pkg.sv
// Shared definitions for the DMux8Way round-robin dispatcher.
//   DISP_LANES   number of downstream lanes
//   DISP_SEL_W   width of a lane index
//   DISP_CNT_W   default width of the optional transfer counter
//   disp_state_e dispatcher holding-register state (EMPTY / FULL)
package dmux8way_dispatcher_pkg;

  localparam int unsigned DISP_LANES = 8;
  localparam int unsigned DISP_SEL_W = 3;
  localparam int unsigned DISP_CNT_W = 16;

  typedef enum logic {
    DISP_EMPTY = 1'b0,
    DISP_FULL  = 1'b1
  } disp_state_e;

  // Lane after `lane`, wrapping 7 -> 0.
  function automatic logic [DISP_SEL_W-1:0] next_lane(input logic [DISP_SEL_W-1:0] lane);
    return DISP_SEL_W'(lane + DISP_SEL_W'(1));
  endfunction

endpackage

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: routes `in` to the output selected by `sel`.
//   in     : input bit
//   sel    : output index (a = 0 ... h = 7)
//   a .. h : outputs, at most one high
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  assign a = in & (sel == 3'd0);
  assign b = in & (sel == 3'd1);
  assign c = in & (sel == 3'd2);
  assign d = in & (sel == 3'd3);
  assign e = in & (sel == 3'd4);
  assign f = in & (sel == 3'd5);
  assign g = in & (sel == 3'd6);
  assign h = in & (sel == 3'd7);

endmodule

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker over 8 requests.
//   req  : request vector, bit i = lane i
//   ptr  : lane with highest priority this cycle
//   pick : first requesting lane scanning ptr, ptr+1, ... (mod 8); ptr when none
//   any  : at least one request present
module rr_pick8
  import dmux8way_dispatcher_pkg::*;
(
  input  logic [DISP_LANES-1:0] req,
  input  logic [DISP_SEL_W-1:0] ptr,
  output logic [DISP_SEL_W-1:0] pick,
  output logic                  any
);

  logic                  found;
  logic [DISP_SEL_W-1:0] idx;

  // Scan from ptr upward; 3-bit addition provides the wrap.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int unsigned k = 0; k < DISP_LANES; k++) begin
      idx = DISP_SEL_W'(ptr + DISP_SEL_W'(k));
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/dmux8way_dispatcher.sv
// Round-robin dispatcher: one valid/ready upstream stream fanned out to 8 lanes.
// A one-word holding register is offered to the next ready lane in rotating
// order; the one-hot lane_valid comes from a DMux8Way driven by sel.
// Optional transfer counter enabled by defining DISPATCH_COUNT_EN.
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : upstream word present
//   in_data     : upstream word
//   in_ready    : dispatcher accepts a word this cycle
//   lane_ready  : per-lane ready
//   lane_valid  : one-hot per-lane valid
//   lane_data   : held word, broadcast to all lanes
//   sel         : lane currently offered
//   xfer_count  : saturating transfer count (DISPATCH_COUNT_EN only)
module dmux8way_dispatcher
  import dmux8way_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH = 8
`ifdef DISPATCH_COUNT_EN
  , parameter int unsigned CNT_W = DISP_CNT_W
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic [DISP_LANES-1:0] lane_ready,
  output logic [DISP_LANES-1:0] lane_valid,
  output logic [WIDTH-1:0]      lane_data,
  output logic [DISP_SEL_W-1:0] sel
`ifdef DISPATCH_COUNT_EN
  , output logic [CNT_W-1:0]    xfer_count
`endif
);

  disp_state_e           state_q, state_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic [DISP_SEL_W-1:0] ptr_q, ptr_d;

  logic [DISP_SEL_W-1:0] pick;
  logic                  any_rdy;
  logic                  full;
  logic                  xfer;
  logic                  accept;

  rr_pick8 u_pick (
    .req  (lane_ready),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any_rdy)
  );

  assign full     = (state_q == DISP_FULL);
  assign xfer     = full & any_rdy;
  // Ready also while a transfer drains the register: pass-through refill.
  assign in_ready = ~full | xfer;
  assign accept   = in_valid & in_ready;
  assign sel      = xfer ? pick : ptr_q;
  assign lane_data = hold_q;

  DMux8Way u_dmux (
    .in  (xfer),
    .sel (sel),
    .a   (lane_valid[0]),
    .b   (lane_valid[1]),
    .c   (lane_valid[2]),
    .d   (lane_valid[3]),
    .e   (lane_valid[4]),
    .f   (lane_valid[5]),
    .g   (lane_valid[6]),
    .h   (lane_valid[7])
  );

  // Next state: a new word always wins; otherwise a transfer empties the register.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      ptr_d   = next_lane(sel);
      state_d = DISP_EMPTY;
    end
    if (accept) begin
      hold_d  = in_data;
      state_d = DISP_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISP_EMPTY;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef DISPATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of completed transfers.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_dmux8way_dispatcher.sv
// Self-checking bench for dmux8way_dispatcher: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based behavioural model.
module tb_dmux8way_dispatcher;

  localparam int unsigned WIDTH = 8;
`ifdef DISPATCH_COUNT_EN
  localparam int unsigned TB_CNT_W = 4;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [7:0]       lane_ready;
  logic [7:0]       lane_valid;
  logic [WIDTH-1:0] lane_data;
  logic [2:0]       sel;
`ifdef DISPATCH_COUNT_EN
  logic [TB_CNT_W-1:0] xfer_count;
`endif

  dmux8way_dispatcher #(
    .WIDTH (WIDTH)
`ifdef DISPATCH_COUNT_EN
    , .CNT_W (TB_CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .lane_ready (lane_ready),
    .lane_valid (lane_valid),
    .lane_data  (lane_data),
    .sel        (sel)
`ifdef DISPATCH_COUNT_EN
    , .xfer_count (xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a one-deep word queue, a rotating priority lane and a count.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_hold;
  int               m_ptr;
  int               m_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int first_ready(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_check();
    int pk;
    bit mfull, xf;
    logic [7:0] ev;
    pk    = first_ready(lane_ready, m_ptr);
    mfull = (mq.size() != 0);
    xf    = mfull && (pk >= 0);
    ev    = 8'h00;
    if (xf) ev[pk] = 1'b1;
    chk("m_lane_valid", 32'(lane_valid), 32'(ev));
    chk("m_sel",        32'(sel),        xf ? 32'(pk) : 32'(m_ptr));
    chk("m_in_ready",   32'(in_ready),   32'(!mfull || xf));
    chk("m_lane_data",  32'(lane_data),  32'(m_hold));
`ifdef DISPATCH_COUNT_EN
    chk("m_xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
  endtask

  task automatic model_update();
    int pk;
    bit mfull, xf, rdy;
    if (reset) begin
      mq.delete();
      m_hold = '0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else begin
      pk    = first_ready(lane_ready, m_ptr);
      mfull = (mq.size() != 0);
      xf    = mfull && (pk >= 0);
      rdy   = !mfull || xf;
      if (xf) begin
        void'(mq.pop_front());
        m_ptr = (pk + 1) % 8;
`ifdef DISPATCH_COUNT_EN
        if (m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
`endif
      end
      if (in_valid && rdy) begin
        mq.push_back(in_data);
        m_hold = in_data;
      end
    end
  endtask

  // Sample mid-cycle and compare against the model.
  task automatic at_neg();
    @(negedge clk);
    model_check();
  endtask

  // Advance one edge; inputs change 1 time unit later.
  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    at_neg();
    adv();
    reset = 1'b0;
  endtask

  logic [7:0] rr_seq [10];

  initial begin
    rr_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    m_hold = '0; m_ptr = 0; m_cnt = 0;

    // Reset held with a word presented: it must be ignored.
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hAA; lane_ready = 8'hFF;
    @(posedge clk);
    model_update();
    #1;
    for (int c = 0; c < 2; c++) begin
      at_neg();
      chk("rst_lane_valid", 32'(lane_valid), 32'h0);
      chk("rst_in_ready",   32'(in_ready),   32'h1);
      chk("rst_sel",        32'(sel),        32'h0);
      adv();
    end
    reset = 1'b0; in_valid = 1'b0;
    at_neg();
    chk("post_rst_lane_valid", 32'(lane_valid), 32'h0);
    chk("post_rst_in_ready",   32'(in_ready),   32'h1);
    adv();

    // Round-robin over all-ready lanes, back to back.
    lane_ready = 8'hFF;
    for (int i = 0; i <= 10; i++) begin
      in_valid = (i < 10);
      in_data  = 8'(8'h10 + i);
      at_neg();
      if (i >= 1) begin
        chk("rr_lane_valid", 32'(lane_valid), 32'(rr_seq[i-1]));
        chk("rr_lane_data",  32'(lane_data),  32'(8'h10 + i - 1));
        chk("rr_in_ready",   32'(in_ready),   32'h1);
      end
      adv();
    end
    in_valid = 1'b0;

    // Skip busy lanes.
    do_reset();
    lane_ready = 8'b0010_0100;
    in_valid = 1'b1; in_data = 8'h33;
    at_neg(); adv();
    in_data = 8'h44;
    at_neg();
    chk("skip_lane_valid_33", 32'(lane_valid), 32'h04);
    chk("skip_lane_data_33",  32'(lane_data),  32'h33);
    adv();
    in_valid = 1'b0;
    at_neg();
    chk("skip_lane_valid_44", 32'(lane_valid), 32'h20);
    chk("skip_lane_data_44",  32'(lane_data),  32'h44);
    adv();
    at_neg();
    chk("skip_ptr6", 32'(sel), 32'h6);
    adv();

    // Stall with no lanes ready, a competing word presented.
    lane_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'h5A;
    at_neg(); adv();
    in_data = 8'h77;
    for (int c = 0; c < 10; c++) begin
      at_neg();
      chk("stall_lane_valid", 32'(lane_valid), 32'h0);
      chk("stall_in_ready",   32'(in_ready),   32'h0);
      chk("stall_lane_data",  32'(lane_data),  32'h5A);
      adv();
    end
    in_valid = 1'b0;
    lane_ready = 8'h08;
    at_neg();
    chk("stall_release_valid", 32'(lane_valid), 32'h08);
    chk("stall_release_data",  32'(lane_data),  32'h5A);
    adv();
    at_neg();
    chk("stall_ptr4", 32'(sel), 32'h4);
    adv();

    // Wrap 7 -> 0 with pass-through refill.
    do_reset();
    lane_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 7);
      in_data  = 8'($urandom);
      at_neg(); adv();
    end
    lane_ready = 8'h81;
    in_valid = 1'b1; in_data = 8'hA1;
    at_neg();
    chk("wrap_ptr7",     32'(sel),      32'h7);
    chk("wrap_in_ready", 32'(in_ready), 32'h1);
    adv();
    in_data = 8'hA2;
    at_neg();
    chk("wrap_a1_valid", 32'(lane_valid), 32'h80);
    chk("wrap_a1_data",  32'(lane_data),  32'hA1);
    chk("wrap_a1_ready", 32'(in_ready),   32'h1);
    adv();
    in_valid = 1'b0;
    at_neg();
    chk("wrap_a2_valid", 32'(lane_valid), 32'h01);
    chk("wrap_a2_data",  32'(lane_data),  32'hA2);
    adv();

`ifdef DISPATCH_COUNT_EN
    // Saturating counter over 20 transfers.
    do_reset();
    at_neg();
    chk("cnt_after_reset", 32'(xfer_count), 32'h0);
    adv();
    lane_ready = 8'hFF;
    for (int i = 0; i <= 20; i++) begin
      in_valid = (i < 20);
      in_data  = 8'(i);
      at_neg(); adv();
    end
    in_valid = 1'b0;
    at_neg();
    chk("cnt_saturated", 32'(xfer_count), 32'd15);
    adv();
    do_reset();
    at_neg();
    chk("cnt_cleared", 32'(xfer_count), 32'h0);
    adv();
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset    = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      lane_ready = 8'h00;
      else if (r == 1) lane_ready = 8'hFF;
      else             lane_ready = 8'($urandom & $urandom);
      at_neg(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
